// File: rtl/sensor_frame_capture_pkg.sv
// Shared definitions for the sensor frame capture block: FSM encoding,
// default geometry and the sample data width.
package sensor_frame_capture_pkg;

    localparam int DATA_W                   = 8;
    localparam int DEFAULT_WIDTH            = 200;
    localparam int DEFAULT_ID_W             = 8;
    localparam int DEFAULT_MAX_FRAME_CYCLES = 1024;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_e;

endpackage

// File: rtl/sensor_frame_capture_shadow.sv
// Shadow register file that accumulates one frame of samples and tracks
// per-frame duplicate and out-of-range ids until it is cleared.
module sensor_shadow_bank
    import sensor_frame_capture_pkg::*;
#(
    parameter int width = DEFAULT_WIDTH,
    parameter int id_w  = DEFAULT_ID_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    we_i,
    input  logic [id_w-1:0]         id_i,
    input  logic [DATA_W-1:0]       data_i,
    output logic [DATA_W*width-1:0] data_o,
    output logic [width-1:0]        en_o,
    output logic                    dup_o,
    output logic                    id_err_o
);

    logic [DATA_W-1:0] mem_q [width];
    logic [width-1:0]  en_q;
    logic [width-1:0]  sel;
    logic              dup_q;
    logic              oor_q;
    logic              in_range;
    logic              dup_hit;

    always_comb begin
        sel = '0;
        for (int k = 0; k < width; k++) begin
            sel[k] = we_i && (id_i == id_w'(k));
        end
    end

    assign in_range = (int'(id_i) < width);
    assign dup_hit  = |(sel & en_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the data array is reset on purpose; retained slots reach the outputs.
            for (int k = 0; k < width; k++) begin
                mem_q[k] <= '0;
            end
            en_q  <= '0;
            dup_q <= 1'b0;
            oor_q <= 1'b0;
        end else if (clear_i) begin
            en_q  <= '0;
            dup_q <= 1'b0;
            oor_q <= 1'b0;
        end else begin
            for (int k = 0; k < width; k++) begin
                if (sel[k]) begin
                    mem_q[k] <= data_i;
                end
            end
            en_q <= en_q | sel;
            if (dup_hit) begin
                dup_q <= 1'b1;
            end
            if (we_i && !in_range) begin
                oor_q <= 1'b1;
            end
        end
    end

    for (genvar k = 0; k < width; k++) begin : g_flat
        assign data_o[DATA_W*k +: DATA_W] = mem_q[k];
    end

    assign en_o     = en_q;
    assign dup_o    = dup_q;
    assign id_err_o = oor_q;

endmodule

// File: rtl/sensor_frame_capture.sv
// Frame capture front end: collects serial samples into the shadow bank and
// publishes a coherent parallel snapshot one cycle after the frame closes.
module sensor_frame_capture
    import sensor_frame_capture_pkg::*;
#(
    parameter int width            = DEFAULT_WIDTH,
    parameter int id_w             = DEFAULT_ID_W,
    parameter int max_frame_cycles = DEFAULT_MAX_FRAME_CYCLES
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    frame_start_i,
    input  logic                    frame_end_i,
    input  logic                    sample_valid_i,
    output logic                    sample_ready_o,
    input  logic [id_w-1:0]         sample_id_i,
    input  logic [DATA_W-1:0]       sample_data_i,
    output logic [DATA_W*width-1:0] sensors_data_o,
    output logic [width-1:0]        sensors_en_o,
    output logic                    frame_valid_o,
    output logic                    frame_timeout_o,
    output logic                    id_err_o,
    output logic                    dup_err_o
);

    localparam int               CNT_W    = (max_frame_cycles > 1) ? $clog2(max_frame_cycles) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(max_frame_cycles - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    logic               bank_clear;
    logic               bank_we;
    logic               commit;

    logic [DATA_W*width-1:0] bank_data;
    logic [width-1:0]        bank_en;
    logic                    bank_dup;
    logic                    bank_oor;

    logic [DATA_W*width-1:0] data_q;
    logic [width-1:0]        en_q;
    logic                    valid_q;
    logic                    timeout_flag_q;
    logic                    id_err_q;
    logic                    dup_err_q;

    assign sample_ready_o = (state_q == ST_COLLECT);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        timeout_d  = timeout_q;
        bank_clear = 1'b0;
        bank_we    = 1'b0;
        commit     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start_i) begin
                    bank_clear = 1'b1;
                    cnt_d      = '0;
                    timeout_d  = 1'b0;
                    state_d    = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                // A restart wins over a close and drops the sample of that cycle.
                if (frame_start_i) begin
                    bank_clear = 1'b1;
                    cnt_d      = '0;
                    timeout_d  = 1'b0;
                end else begin
                    bank_we = sample_valid_i && sample_ready_o;
                    if (cnt_q != CNT_LAST) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (frame_end_i) begin
                        state_d = ST_COMMIT;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = ST_COMMIT;
                        timeout_d = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            timeout_q      <= 1'b0;
            data_q         <= '0;
            en_q           <= '0;
            valid_q        <= 1'b0;
            timeout_flag_q <= 1'b0;
            id_err_q       <= 1'b0;
            dup_err_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            valid_q   <= commit;
            if (commit) begin
                data_q         <= bank_data;
                en_q           <= bank_en;
                timeout_flag_q <= timeout_q;
                id_err_q       <= bank_oor;
                dup_err_q      <= bank_dup;
            end
        end
    end

    sensor_shadow_bank #(
        .width (width),
        .id_w  (id_w)
    ) u_shadow (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (bank_clear),
        .we_i     (bank_we),
        .id_i     (sample_id_i),
        .data_i   (sample_data_i),
        .data_o   (bank_data),
        .en_o     (bank_en),
        .dup_o    (bank_dup),
        .id_err_o (bank_oor)
    );

    assign sensors_data_o  = data_q;
    assign sensors_en_o    = en_q;
    assign frame_valid_o   = valid_q;
    assign frame_timeout_o = timeout_flag_q;
    assign id_err_o        = id_err_q;
    assign dup_err_o       = dup_err_q;

endmodule
